// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: video (real-time) vs CPU (best-effort) with bounded CPU starvation.
// Optional statistics outputs when FB_ARB_STATS_EN is defined.
module fb_read_arbiter #(
    parameter int unsigned AW         = 17,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_gnt,
    output logic          cpu_valid,
    output logic [DW-1:0] cpu_data,
    output logic [AW-1:0] rdaddress,
    input  logic [DW-1:0] q
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]   cpu_stall_cycles,
    output logic [7:0]    forced_grants
`endif
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]   starve_cnt;
    logic            starve_at_max;
    logic [RD_LAT:0] tag_v;
    logic [RD_LAT:0] tag_cpu;

    assign starve_at_max = (starve_cnt == STARVE_LIM);

    // Grants are gated by reset so nothing is handshaken while the block is held in reset.
    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (reset) begin
            if (vid_req && cpu_req) begin
                if (starve_at_max) cpu_gnt = 1'b1;
                else               vid_gnt = 1'b1;
            end else begin
                vid_gnt = vid_req;
                cpu_gnt = cpu_req;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_cnt <= '0;
        end else if (!starve_at_max) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdaddress <= '0;
        end else if (vid_gnt) begin
            rdaddress <= vid_addr;
        end else if (cpu_gnt) begin
            rdaddress <= cpu_addr;
        end
    end

    // Tag stage RD_LAT lines up with the cycle in which q holds the data for that read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v   <= '0;
            tag_cpu <= '0;
        end else begin
            tag_v   <= {tag_v[RD_LAT-1:0], vid_gnt | cpu_gnt};
            tag_cpu <= {tag_cpu[RD_LAT-1:0], cpu_gnt};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_valid <= 1'b0;
            cpu_valid <= 1'b0;
            vid_data  <= '0;
            cpu_data  <= '0;
        end else begin
            vid_valid <= 1'b0;
            cpu_valid <= 1'b0;
            if (tag_v[RD_LAT]) begin
                if (tag_cpu[RD_LAT]) begin
                    cpu_data  <= q;
                    cpu_valid <= 1'b1;
                end else begin
                    vid_data  <= q;
                    vid_valid <= 1'b1;
                end
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_stall_cycles <= '0;
            forced_grants    <= '0;
        end else begin
            if (cpu_req && !cpu_gnt && (cpu_stall_cycles != '1))
                cpu_stall_cycles <= cpu_stall_cycles + 1'b1;
            if (cpu_gnt && vid_req && (forced_grants != '1))
                forced_grants <= forced_grants + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Scoreboard bench for fb_read_arbiter: directed stimulus pushes expected responses, a monitor pops and checks.
module tb_fb_read_arbiter;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_gnt, vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_gnt, cpu_valid;
    logic [DW-1:0] cpu_data;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q = '0;
    logic [AW-1:0] ra1 = '0;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   cpu_stall_cycles;
    logic [7:0]    forced_grants;
`endif

    fb_read_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .rdaddress(rdaddress), .q(q)
`ifdef FB_ARB_STATS_EN
        , .cpu_stall_cycles(cpu_stall_cycles), .forced_grants(forced_grants)
`endif
    );

    always #5 clk = ~clk;

    // Two-cycle RAM whose contents are a fixed pattern of the address.
    always @(posedge clk) begin
        ra1 <= rdaddress;
        q   <= 32'hDEAD_0000 ^ {15'b0, ra1};
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          cpu;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (vid_valid || cpu_valid) begin
            chk("valid_exclusive", {31'b0, vid_valid & cpu_valid}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", {30'b0, vid_valid, cpu_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_owner", {31'b0, cpu_valid}, {31'b0, e.cpu});
                chk("resp_data", cpu_valid ? cpu_data : vid_data, e.data);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic drive(input bit vr, input logic [AW-1:0] va, input bit cr,
                         input logic [AW-1:0] ca, input bit ev, input bit ec);
        exp_t e;
        vid_req = vr; vid_addr = va; cpu_req = cr; cpu_addr = ca;
        @(negedge clk);
        chk("vid_gnt", {31'b0, vid_gnt}, {31'b0, ev});
        chk("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, ec});
        if (ev || ec) begin
            e.cpu  = ec;
            e.data = 32'hDEAD_0000 ^ {15'b0, (ec ? ca : va)};
            e.cyc  = cyc + 4;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] va, ca;
        bit f;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Single video read; rdaddress registered one cycle after grant
        drive(1'b1, 17'h00010, 1'b0, '0, 1'b1, 1'b0);
        vid_req = 1'b0;
        @(negedge clk);
        chk("rdaddress_single", {15'b0, rdaddress}, 32'h10);
        @(posedge clk); #1;
        idle(5);

        // Back-to-back interleave
        drive(1'b1, 17'h00100, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 17'h00200, 1'b0, 1'b1);
        drive(1'b1, 17'h00101, 1'b0, '0, 1'b1, 1'b0);
        idle(6);

        // Starvation: forced CPU grants in cycles 8 and 17
        va = 17'h00300; ca = 17'h003F0;
        for (int c = 0; c < 20; c++) begin
            f = (c == 8) || (c == 17);
            drive(1'b1, va, 1'b1, ca, !f, f);
            if (f) ca++; else va++;
        end
        vid_req = 1'b0; cpu_req = 1'b0;
`ifdef FB_ARB_STATS_EN
        @(negedge clk);
        chk("forced_grants", {24'b0, forced_grants}, 32'd2);
        chk("cpu_stall_cycles", {16'b0, cpu_stall_cycles}, 32'd18);
        @(posedge clk); #1;
`endif
        idle(6);

        // Dropped CPU request restarts the starvation count
        va = 17'h00400; ca = 17'h004F0;
        for (int c = 0; c < 17; c++) begin
            f = (c == 14);
            drive(1'b1, va, c != 5, ca, !f, f);
            if (f) ca++; else va++;
        end
        idle(6);

        // Reset with three reads in flight
        drive(1'b1, 17'h00500, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 17'h00501, 1'b0, 1'b1);
        drive(1'b1, 17'h00502, 1'b0, '0, 1'b1, 1'b0);
        vid_req = 1'b1; cpu_req = 1'b1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_vid_gnt", {31'b0, vid_gnt}, 32'd0);
        chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
        chk("rst_rdaddress", {15'b0, rdaddress}, 32'd0);
        chk("rst_vid_data", vid_data, 32'd0);
        chk("rst_cpu_data", cpu_data, 32'd0);
        chk("rst_valids", {30'b0, vid_valid, cpu_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        idle(6);
        drive(1'b1, 17'h00055, 1'b0, '0, 1'b1, 1'b0);
        idle(6);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
